ycbcr_to_rgb: RTL and testbench

//  Converts 8-bit unsigned Y/Cb/Cr pixels (full-range JFIF, Cb/Cr offset 128) back to 8-bit R/G/B.
//  It is the inverse colour stage of the encoder's RGB->YCbCr converter. It sits at the decoder/preview

---
 rtl/ycbcr_to_rgb.sv | 141 ++++++++++++++
 tb/tb_ycbcr_to_rgb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_to_rgb.sv
// Full-range JFIF YCbCr -> RGB converter: 3-stage elastic pipeline (offset, multiply-add, round/clamp)
// with valid/ready on both sides and a saturating count of clamped output components.
module ycbcr_to_rgb #(
    parameter int FRAC_BITS = 13,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      data_out,
    output logic [CNT_W-1:0] sat_count,
    input  logic             sat_clr
);

    localparam logic signed [23:0] K_R_CR = 24'sd11485;
    localparam logic signed [23:0] K_G_CB = 24'sd2819;
    localparam logic signed [23:0] K_G_CR = 24'sd5850;
    localparam logic signed [23:0] K_B_CB = 24'sd14516;
    localparam logic signed [23:0] HALF   = 24'sd1 <<< (FRAC_BITS - 1);

    // Returns {clamped_flag, component}; round-half-up then clamp to 0..255.
    function automatic logic [8:0] round_clamp(input logic signed [23:0] acc);
        logic signed [23:0] v;
        v = (acc + HALF) >>> FRAC_BITS;
        if (v < 24'sd0)
            round_clamp = {1'b1, 8'h00};
        else if (v > 24'sd255)
            round_clamp = {1'b1, 8'hFF};
        else
            round_clamp = {1'b0, v[7:0]};
    endfunction

    logic                started;
    logic                v1;
    logic signed [8:0]   dcb;
    logic signed [8:0]   dcr;
    logic signed [23:0]  ys;
    logic                v2;
    logic signed [23:0]  r_acc;
    logic signed [23:0]  g_acc;
    logic signed [23:0]  b_acc;

    logic                ready2;
    logic                ready3;
    logic signed [8:0]   dcb_n;
    logic signed [8:0]   dcr_n;
    logic signed [23:0]  ys_n;
    logic signed [23:0]  dcb_ext;
    logic signed [23:0]  dcr_ext;
    logic signed [23:0]  r_n;
    logic signed [23:0]  g_n;
    logic signed [23:0]  b_n;
    logic [8:0]          r_c;
    logic [8:0]          g_c;
    logic [8:0]          b_c;
    logic [1:0]          n_clamp;
    logic [CNT_W:0]      sat_sum;
    logic [CNT_W-1:0]    sat_next;

    // Ready chain runs backwards from the output so bubbles collapse in one cycle.
    assign ready3   = !out_valid || out_ready;
    assign ready2   = !v2 || ready3;
    assign in_ready = started && (!v1 || ready2);

    always_comb begin
        dcb_n   = $signed({1'b0, data_in[15:8]}) - 9'sd128;
        dcr_n   = $signed({1'b0, data_in[23:16]}) - 9'sd128;
        ys_n    = $signed(24'(data_in[7:0]) << FRAC_BITS);
        dcb_ext = 24'(dcb);
        dcr_ext = 24'(dcr);
        r_n     = ys + K_R_CR * dcr_ext;
        g_n     = ys - K_G_CB * dcb_ext - K_G_CR * dcr_ext;
        b_n     = ys + K_B_CB * dcb_ext;
        r_c     = round_clamp(r_acc);
        g_c     = round_clamp(g_acc);
        b_c     = round_clamp(b_acc);
        n_clamp = {1'b0, r_c[8]} + {1'b0, g_c[8]} + {1'b0, b_c[8]};
        sat_sum = {1'b0, sat_count} + {{(CNT_W-1){1'b0}}, n_clamp};
        sat_next = sat_sum[CNT_W] ? {CNT_W{1'b1}} : sat_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            v1      <= 1'b0;
            dcb     <= '0;
            dcr     <= '0;
            ys      <= '0;
        end else begin
            started <= 1'b1;
            if (in_ready) begin
                v1 <= in_valid;
                if (in_valid) begin
                    dcb <= dcb_n;
                    dcr <= dcr_n;
                    ys  <= ys_n;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            r_acc <= '0;
            g_acc <= '0;
            b_acc <= '0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                r_acc <= r_n;
                g_acc <= g_n;
                b_acc <= b_n;
            end
        end
    end

    // Clamps are counted as the pixel enters the output register; clear beats the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sat_count <= '0;
        end else begin
            if (ready3) begin
                out_valid <= v2;
                if (v2)
                    data_out <= {b_c[7:0], g_c[7:0], r_c[7:0]};
            end
            if (sat_clr)
                sat_count <= '0;
            else if (ready3 && v2)
                sat_count <= sat_next;
        end
    end

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Self-checking bench for ycbcr_to_rgb: directed colour points, backpressure, random traffic
// against an arithmetic reference model, mid-stream reset and sat_count saturation/clear.
module tb_ycbcr_to_rgb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sat_clr = 1'b0;
    logic [23:0] data_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] data_out;
    logic [15:0] sat_count;

    int          total = 0;
    int          bad = 0;
    logic [23:0] exp_q[$];
    int          popped = 0;
    longint      clamp_total = 0;
    int          mon_clamps;
    logic [23:0] last_out = '0;
    bit          mon_en = 1'b0;

    ycbcr_to_rgb #(.FRAC_BITS(13), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .sat_count(sat_count), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    // Reference: JFIF inverse with the 2^13-scaled constants, round half up, clamp to 0..255.
    function automatic logic [23:0] ref_rgb(input logic [23:0] p, output int clamps);
        int y, cb, cr, v;
        int acc[3];
        logic [23:0] res;
        y  = int'(p[7:0]);
        cb = int'(p[15:8]) - 128;
        cr = int'(p[23:16]) - 128;
        acc[0] = y * 8192 + 11485 * cr;
        acc[1] = y * 8192 - 2819 * cb - 5850 * cr;
        acc[2] = y * 8192 + 14516 * cb;
        clamps = 0;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            v = (acc[k] + 4096) >>> 13;
            if (v < 0) begin
                v = 0;
                clamps++;
            end else if (v > 255) begin
                v = 255;
                clamps++;
            end
            res[8*k +: 8] = 8'(v);
        end
        return res;
    endfunction

    function automatic logic [15:0] sat_expected();
        return (clamp_total > 65535) ? 16'hFFFF : 16'(clamp_total);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_rgb(data_in, mon_clamps));
                clamp_total += mon_clamps;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    check_output("pixel", 32'(data_out), 32'(exp_q.pop_front()));
                    last_out = data_out;
                    popped++;
                end
            end
        end
    end

    task automatic send_pixel(input logic [23:0] pix);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        data_in  = pix;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_output("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_stimulus(input int n_pix);
        int acc_cnt;
        acc_cnt = 0;
        for (int cyc = 0; cyc < 60000 && acc_cnt < n_pix; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            data_in   = 24'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_output("random_accepted", 32'(acc_cnt), 32'(n_pix));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          acc_cnt;
        int          p0;
        logic [23:0] held;
        logic [23:0] bp_pix[5];

        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_data_out", 32'(data_out), 32'd0);
        check_output("rst_sat_count", 32'(sat_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check_output("in_ready_after_rst", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Mid-grey: exact latency and value.
        send_pixel(24'h808080);
        check_output("lat_cycle1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_output("lat_cycle2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_output("lat_cycle3_valid", 32'(out_valid), 32'd1);
        check_output("lat_cycle3_data", 32'(data_out), 32'h808080);
        drain("drain_grey");
        check_output("grey_sat", 32'(sat_count), 32'd0);

        send_pixel(24'hFF554C);
        drain("drain_red");
        check_output("red_value", 32'(last_out), 32'h0000FE);
        check_output("red_sat", 32'(sat_count), 32'd0);

        send_pixel(24'hFFFFFF);
        drain("drain_white");
        check_output("white_value", 32'(last_out), 32'hFF79FF);
        check_output("white_sat", 32'(sat_count), 32'd2);
        send_pixel(24'h000000);
        drain("drain_black");
        check_output("black_value", 32'(last_out), 32'h008700);
        check_output("black_sat", 32'(sat_count), 32'd4);

        // Backpressure: five pixels offered against a stalled output.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) bp_pix[i] = 24'($urandom);
        acc_cnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = 1'b1;
            data_in  = bp_pix[acc_cnt];
            @(negedge clk);
            if (in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        check_output("bp_accepted", 32'(acc_cnt), 32'd3);
        check_output("bp_in_ready", 32'(in_ready), 32'd0);
        check_output("bp_out_valid", 32'(out_valid), 32'd1);
        held = data_out;
        repeat (3) @(posedge clk);
        #1;
        check_output("bp_stable", 32'(data_out), 32'(held));
        out_ready = 1'b1;
        p0 = popped;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (acc_cnt < 5);
            data_in  = bp_pix[(acc_cnt < 5) ? acc_cnt : 4];
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_output("bp_pops_5_cycles", 32'(popped - p0), 32'd5);
        check_output("bp_all_accepted", 32'(acc_cnt), 32'd5);
        drain("drain_bp");

        apply_stimulus(10000);
        drain("drain_random");
        check_output("random_sat", 32'(sat_count), 32'(sat_expected()));

        // Reset with pixels in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 24'($urandom);
        @(posedge clk);
        #1;
        data_in = 24'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check_output("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_out_valid", 32'(out_valid), 32'd0);
        check_output("async_rst_data_out", 32'(data_out), 32'd0);
        check_output("async_rst_sat", 32'(sat_count), 32'd0);
        exp_q.delete();
        clamp_total = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("in_ready_after_rst2", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        p0 = popped;
        repeat (10) @(posedge clk);
        #1;
        check_output("no_ghost_pixels", 32'(popped - p0), 32'd0);
        check_output("no_ghost_valid", 32'(out_valid), 32'd0);

        // Drive sat_count past all-ones: two clamps per pixel.
        in_valid = 1'b1;
        data_in  = 24'hFFFFFF;
        acc_cnt  = 0;
        for (int cyc = 0; cyc < 40000 && acc_cnt < 32770; cyc++) begin
            @(negedge clk);
            if (in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain("drain_sat");
        check_output("sat_sticky", 32'(sat_count), 32'(sat_expected()));
        check_output("sat_all_ones", 32'(sat_count), 32'h0000FFFF);

        // Clear collides with a clamped pixel entering the output register.
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        sat_clr  = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check_output("clr_wins", 32'(sat_count), 32'd0);
        drain("drain_clr");
        check_output("after_clr", 32'(sat_count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
